// File: rtl/ccr_pipe.sv
// ccr_pipe: condition-code flag pipeline from EX through M and W.
// Forwards the youngest in-flight C/Z to the ALU and commits at writeback.
module ccr_pipe #(
    parameter logic RESET_C = 1'b0,
    parameter logic RESET_Z = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_ccr_enable,
    input  logic        ex_carry_wr,
    input  logic        ex_carry,
    input  logic        ex_zero,
    input  logic        stall,
    input  logic        flush,
    input  logic        mem_load_zero_wr,
    input  logic [15:0] mem_load_data,
    output logic        carry_in,
    output logic        zero_in,
    output logic        arch_carry,
    output logic        arch_zero,
    output logic        wb_commit
);

    typedef struct packed {
        logic v;
        logic cwr;
        logic zwr;
        logic c;
        logic z;
    } flag_t;

    flag_t r_m;
    flag_t r_w;
    flag_t w_cap;
    flag_t w_m_eff;
    logic  r_arch_c;
    logic  r_arch_z;
    logic  r_commit;
    logic  w_ld;
    logic  w_commit_en;

    // Build the M entry from the ALU flag outputs in EX.
    always_comb begin
        w_cap.v   = ex_valid;
        w_cap.zwr = ex_valid & ex_ccr_enable;
        w_cap.cwr = ex_valid & ex_ccr_enable & ex_carry_wr;
        w_cap.c   = ex_carry;
        w_cap.z   = ex_zero;
    end

    // M entry as seen by W and the forward path: LW overrides Z.
    always_comb begin
        w_m_eff = r_m;
        w_ld    = r_m.v & mem_load_zero_wr;
        if (w_ld) begin
            w_m_eff.zwr = 1'b1;
            w_m_eff.z   = (mem_load_data == 16'h0000);
        end
    end

    // Youngest valid writer wins, chosen independently per flag.
    always_comb begin
        carry_in = r_arch_c;
        zero_in  = r_arch_z;
        if (w_m_eff.v & w_m_eff.cwr) begin
            carry_in = w_m_eff.c;
        end else if (r_w.v & r_w.cwr) begin
            carry_in = r_w.c;
        end
        if (w_m_eff.v & w_m_eff.zwr) begin
            zero_in = w_m_eff.z;
        end else if (r_w.v & r_w.zwr) begin
            zero_in = r_w.z;
        end
    end

    // W retires whenever the pipe advances; flush still lets W commit.
    assign w_commit_en = r_w.v & (flush | ~stall);

    // Stage registers, architectural flags and the commit pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m      <= '0;
            r_w      <= '0;
            r_arch_c <= RESET_C;
            r_arch_z <= RESET_Z;
            r_commit <= 1'b0;
        end else begin
            if (flush) begin
                r_m <= '0;
                r_w <= '0;
            end else if (!stall) begin
                r_m <= w_cap;
                r_w <= w_m_eff;
            end
            if (w_commit_en & r_w.cwr) begin
                r_arch_c <= r_w.c;
            end
            if (w_commit_en & r_w.zwr) begin
                r_arch_z <= r_w.z;
            end
            r_commit <= w_commit_en & (r_w.cwr | r_w.zwr);
        end
    end

    assign arch_carry = r_arch_c;
    assign arch_zero  = r_arch_z;
    assign wb_commit  = r_commit;

endmodule
